goldschmidt_divsqrt: RTL and testbench



---
 rtl/goldschmidt_divsqrt.sv | 147 ++++++++++++++
 tb/tb_goldschmidt_divsqrt.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_divsqrt.sv
// rtl/goldschmidt_divsqrt.sv - Goldschmidt divide / square-root unit; optional seed ROM via GOLDSCHMIDT_SEED_ROM_EN
module goldschmidt_divsqrt #(
    parameter int WIDTH = 32,
    parameter int ITER  = 5,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             ready,
    output logic             err,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] xn
);
    // x and y are unsigned 2.(WIDTH+2) fixed point: two integer bits, four guard bits overall
    localparam int XW = WIDTH + 4;
    localparam int FB = WIDTH + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

`ifdef GOLDSCHMIDT_SEED_ROM_EN
    localparam int NITER = ITER - 2;
`else
    localparam int NITER = ITER;
`endif
    localparam logic [CW-1:0] LAST = CW'(NITER);

    logic [1:0]       state;
    logic [XW-1:0]    x, y;
    logic             mode, fail;
    logic [XW-1:0]    r_div, r_sqrt, r, yr, x_nxt, y_nxt;
    logic [XW-1:0]    a_ext, b_ext, x_init, y_init;
    logic [WIDTH-1:0] q_nxt;
    logic             bad;

    function automatic logic [XW-1:0] fmul(input logic [XW-1:0] p, input logic [XW-1:0] m);
        logic [2*XW-1:0] full;
        full = {{XW{1'b0}}, p} * {{XW{1'b0}}, m};
        return full[FB +: XW];
    endfunction

    always_comb begin
        r_div  = (XW'(2) << FB) - y;
        r_sqrt = ((XW'(3) << FB) - y) >> 1;
        r      = mode ? r_sqrt : r_div;
        x_nxt  = fmul(x, r);
        yr     = fmul(y, r);
        y_nxt  = mode ? fmul(yr, r) : yr;
    end

    assign a_ext = {2'b00, a, 2'b00};
    assign b_ext = {2'b00, b, 2'b00};
    assign bad   = op ? (a[WIDTH-1:WIDTH-2] == 2'b00) : !(a[WIDTH-1] && b[WIDTH-1]);
    assign q_nxt = x[XW-1] ? '1 : x[XW-2 -: WIDTH];
    assign xn    = x[XW-1 -: WIDTH];

`ifdef GOLDSCHMIDT_SEED_ROM_EN
    // Seeds are 2.10 fixed point, evaluated at the centre of each 1/256 input bucket
    function automatic logic [11:0] isqrt(input longint v);
        logic [11:0] rt;
        logic [11:0] t;
        rt = '0;
        for (int k = 11; k >= 0; k--) begin
            t = rt | (12'd1 << k);
            if (longint'(t) * longint'(t) <= v) rt = t;
        end
        return rt;
    endfunction

    logic [11:0]   rom_div  [256];
    logic [11:0]   rom_odd  [256];
    logic [11:0]   rom_even [256];
    logic [11:0]   s;
    logic [XW-1:0] s_ext;

    for (genvar i = 0; i < 256; i++) begin : g_seed
        localparam longint M = 2 * i + 513;
        assign rom_div[i]  = 12'((longint'(1) << 20) / M);
        assign rom_odd[i]  = isqrt((longint'(1) << 30) / M);
        assign rom_even[i] = isqrt((longint'(1) << 31) / M);
    end

    always_comb begin
        s = rom_div[b[WIDTH-2 -: 8]];
        if (op) s = a[WIDTH-1] ? rom_odd[a[WIDTH-2 -: 8]] : rom_even[a[WIDTH-3 -: 8]];
    end

    assign s_ext  = {s, {(FB-10){1'b0}}};
    assign x_init = fmul(a_ext, s_ext);
    assign y_init = op ? fmul(x_init, s_ext) : fmul(b_ext, s_ext);
`else
    assign x_init = a_ext;
    assign y_init = op ? a_ext : b_ext;
`endif

    // A rejected operand spends one non-busy cycle in RUN so ready lands one cycle after accept
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            mode  <= 1'b0;
            fail  <= 1'b0;
            q     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
            count <= '0;
        end else begin
            ready <= 1'b0;
            if (state == RUN) begin
                if (fail || count == LAST) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    err   <= fail;
                    count <= '0;
                    q     <= fail ? '1 : q_nxt;
                end else begin
                    x     <= x_nxt;
                    y     <= y_nxt;
                    count <= count + CW'(1);
                end
            end else if (start) begin
                state <= RUN;
                mode  <= op;
                fail  <= bad;
                busy  <= !bad;
                err   <= 1'b0;
                count <= '0;
                if (!bad) begin
                    x <= x_init;
                    y <= y_init;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_goldschmidt_divsqrt.sv
// tb/tb_goldschmidt_divsqrt.sv - directed vector bench for goldschmidt_divsqrt
module tb_goldschmidt_divsqrt;
    localparam int W  = 32;
    localparam int IT = 7;
    localparam int CW = 3;
`ifdef GOLDSCHMIDT_SEED_ROM_EN
    localparam int N = IT - 2;
`else
    localparam int N = IT;
`endif

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  q;
    logic          busy, ready, err;
    logic [CW-1:0] count;
    logic [W-1:0]  xn;

    goldschmidt_divsqrt #(.WIDTH(W), .ITER(IT), .CW(CW)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
        .q(q), .busy(busy), .ready(ready), .err(err), .count(count), .xn(xn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic         err;
    } vec_t;

    vec_t vecs [11];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic run_op(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output logic saw_busy);
        repeat (2) @(negedge clk);
        op = o; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        saw_busy = busy;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy && !ready) saw_busy = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, pulses, rdy_seen;
        logic saw_busy, prev_rdy, gap_bad;
        logic [W-1:0] last_q;

        vecs[0]  = '{1'b1, 32'h40000000, 32'h00000000, 32'h40000000, 1'b0};
        vecs[1]  = '{1'b1, 32'hC0000000, 32'h00000000, 32'h6ED9EBA1, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFE0001, 32'h00000000, 32'h7FFF8000, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'h00000000, 32'h5A827999, 1'b0};
        vecs[4]  = '{1'b0, 32'hC0000000, 32'h80000000, 32'hC0000000, 1'b0};
        vecs[5]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h40000000, 1'b0};
        vecs[6]  = '{1'b0, 32'h80000000, 32'hC0000000, 32'h55555555, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{1'b0, 32'hC0000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{1'b1, 32'h20000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_q", q, 0, 0);
        check("reset_busy", busy, 0, 0);
        check("reset_ready", ready, 0, 0);
        check("reset_err", err, 0, 0);
        check("reset_count", count, 0, 0);
        check("reset_xn", xn, 0, 0);

        @(negedge clk);
        clrn = 1'b1;
        rdy_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ready || busy || err || q != 0 || count != 0) rdy_seen++;
        end
        check("idle_quiet_cycles", rdy_seen, 0, 0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, saw_busy);
            check($sformatf("vec%0d_q", i), q, vecs[i].q, vecs[i].err ? 0 : 4);
            check($sformatf("vec%0d_err", i), err, vecs[i].err, 0);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 1 : N + 1, 0);
            check($sformatf("vec%0d_busy_seen", i), saw_busy, !vecs[i].err, 0);
            check($sformatf("vec%0d_count_done", i), count, 0, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_ready_one_cycle", i), ready, 0, 0);
        end

        // start held high: second op accepted in DONE, busy follows ready directly
        repeat (2) @(negedge clk);
        op = 1'b1; a = 32'hC0000000; b = '0; start = 1'b1;
        pulses = 0; gap_bad = 1'b0; prev_rdy = 1'b0; last_q = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == IT + 3) start = 1'b0;
            if (prev_rdy && pulses == 1 && !busy) gap_bad = 1'b1;
            if (ready) begin
                pulses++;
                last_q = q;
            end
            prev_rdy = ready;
        end
        check("b2b_pulses", pulses, 2, 0);
        check("b2b_busy_after_ready", gap_bad, 0, 0);
        check("b2b_second_q", last_q, 32'h6ED9EBA1, 4);

        // operands change after accept must not affect the result
        repeat (2) @(negedge clk);
        op = 1'b1; a = 32'h80000000; b = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 1'b0; a = 32'h12345678; b = 32'h00000001;
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("captured_q", q, 32'h5A827999, 4);
        check("captured_err", err, 0, 0);

        // reset mid-run at count=2
        repeat (2) @(negedge clk);
        op = 1'b1; a = 32'hC0000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (count != 2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("midrun_reached_count2", count, 2, 0);
        clrn = 1'b0;
        #1;
        check("abort_q", q, 0, 0);
        check("abort_busy", busy, 0, 0);
        check("abort_count", count, 0, 0);
        check("abort_xn", xn, 0, 0);
        rdy_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready) rdy_seen++;
        end
        @(negedge clk);
        clrn = 1'b1;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (ready) rdy_seen++;
        end
        check("abort_no_ready", rdy_seen, 0, 0);
        run_op(1'b0, 32'hC0000000, 32'h80000000, lat, saw_busy);
        check("after_abort_q", q, 32'hC0000000, 4);
        check("after_abort_latency", lat, N + 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
